ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter ITER, default 32, meaning number of iteration cycles; it SHALL equal the operand width.
REQ-003 clock  input  1  rising-edge clock shared with the pipeline registers.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  mul/div instruction valid in EX, taken from the ID/EX outputs.
REQ-006 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Data_1  input  32  rs operand from ID/EX, used as multiplicand or dividend.
REQ-008 Data_2  input  32  rt operand from ID/EX, used as multiplier or divisor.
REQ-009 flush  input  1  abort any in-flight operation (branch taken or exception).
REQ-010 stall  output  1  freeze IF/ID and ID/EX, combinational: busy OR (start AND NOT flush).
REQ-011 busy  output  1  iteration in progress.
REQ-012 done  output  1  one-cycle pulse signalling that HI/LO were updated.
REQ-013 div0  output  1  sticky flag for the last completed divide having a zero divisor.
REQ-014 HI, LO  output  32 each  result registers.

Function
REQ-015 FSM states SHALL be IDLE, RUN and FIN; after reset the FSM SHALL be in IDLE.
REQ-016 IDLE: start=1 and flush=0 at edge E0 SHALL latch operand magnitudes and op, clear the counter and go to RUN.
REQ-017 RUN: one radix-2 step per edge; multiply SHALL be shift-add and divide SHALL be restoring shift-subtract; after ITER steps (edges E1..E32) the FSM SHALL go to FIN.
REQ-018 FIN: at edge E33, HI/LO SHALL load the sign-corrected result, done=1 for the following cycle, and the FSM SHALL return to IDLE.
REQ-019 busy SHALL be 1 in the cycles after edges E0 through E32.
REQ-020 Multiply SHALL produce the full 64-bit product in {HI,LO}.
REQ-021 Divide SHALL place the quotient in LO and the remainder in HI.
REQ-022 Signed divide SHALL truncate toward zero, with the remainder sign equal to the dividend sign.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-024 A divisor of 0 SHALL give HI=dividend, LO=0xFFFFFFFF and div0=1; a completed divide with a nonzero divisor SHALL clear div0, and multiplies SHALL leave div0 unchanged.
REQ-025 start while busy SHALL be ignored, because upstream is stalled.
REQ-026 flush in RUN or FIN SHALL return the FSM to IDLE on the next edge, with no done pulse and HI/LO/div0 unchanged.
REQ-027 start and flush asserted together SHALL start no operation, with flush taking priority.
REQ-028 HI/LO SHALL hold their values between completions.

Reset
REQ-029 reset SHALL asynchronously force state=IDLE, counter=0, busy=0, done=0, div0=0, HI=0, LO=0 and clear all internal operand and accumulator registers.
REQ-030 reset asserted mid-operation SHALL discard the operation, with no done pulse after release.
REQ-031 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-032 The macro MULDIV_SIGNED_EN SHALL control signed-operation support.
REQ-033 With MULDIV_SIGNED_EN defined, MULT and DIV SHALL be two's-complement signed, with magnitude conversion at E0 and conditional negation at FIN.
REQ-034 Without MULDIV_SIGNED_EN, op[0] SHALL be ignored, all operations SHALL be unsigned, and the sign logic SHALL be absent.

Structure
REQ-035 The shared package muldiv_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the FSM state typedef and the constant ITER=32.
REQ-036 One combinational sub-module, muldiv_sign_adj, SHALL provide absolute-value and conditional-negate at 32 and 64 bits; it SHALL be instantiated only under MULDIV_SIGNED_EN.

Verification
REQ-037 MULTU 0xFFFFFFFF x 0xFFFFFFFF SHALL give HI=0xFFFFFFFE, LO=0x00000001, with done exactly 34 cycles after the start edge and stall high throughout.
REQ-038 MULT -3 x 5 (signed build) SHALL give HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-039 DIV -7 / 2 (signed build) SHALL give LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 SHALL give LO=14, HI=2.
REQ-040 DIVU 100 / 0 SHALL give HI=100, LO=0xFFFFFFFF, div0=1; a following DIVU 9/3 SHALL give div0=0, LO=3.
REQ-041 flush at cycle 10 of a MULTU SHALL produce no done pulse, leave HI/LO at their prior values and return busy=0 next cycle; start together with flush SHALL be ignored.
REQ-042 reset pulsed at cycle 20 of a DIV SHALL clear HI/LO/busy immediately, with no done afterwards; a new MULTU 2x3 after release SHALL give LO=6.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the EX-stage iterative multiply/divide unit.
//   OP_*    : operation encodings carried on ex_muldiv.op
//   state_t : IDLE -> RUN (ITER radix-2 steps) -> FIN (write HI/LO) -> IDLE
//   ITER    : iteration count, equal to the operand width
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int unsigned ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_sign_adj.sv
// muldiv_sign_adj: combinational sign handling for signed MULT/DIV.
//   sgn                : operands are two's-complement signed
//   a, b               : raw operands;  a_mag, b_mag : magnitudes (pass-through when !sgn)
//   prod, prod_neg     : 64-bit unsigned product and negate request -> prod_adj
//   quo, quo_neg       : 32-bit quotient and negate request          -> quo_adj
//   rem, rem_neg       : 32-bit remainder and negate request         -> rem_adj
// Only instantiated when MULDIV_SIGNED_EN is defined.
module muldiv_sign_adj (
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] a_mag,
    output logic [31:0] b_mag,
    input  logic [63:0] prod,
    input  logic        prod_neg,
    output logic [63:0] prod_adj,
    input  logic [31:0] quo,
    input  logic        quo_neg,
    output logic [31:0] quo_adj,
    input  logic [31:0] rem,
    input  logic        rem_neg,
    output logic [31:0] rem_adj
);

    // 0x80000000 maps to itself, which is still the correct unsigned magnitude.
    assign a_mag    = (sgn && a[31]) ? (~a + 32'd1) : a;
    assign b_mag    = (sgn && b[31]) ? (~b + 32'd1) : b;

    assign prod_adj = prod_neg ? (~prod + 64'd1) : prod;
    assign quo_adj  = quo_neg  ? (~quo  + 32'd1) : quo;
    assign rem_adj  = rem_neg  ? (~rem  + 32'd1) : rem;

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative radix-2 multiply/divide unit for the EX stage.
//   clock, reset (async, active-high)
//   start, op[1:0], Data_1, Data_2 : operation request from ID/EX
//   flush                          : abort in-flight operation
//   stall                          : busy | (start & ~flush), freezes IF/ID and ID/EX
//   busy, done, div0               : status (done is a one-cycle pulse)
//   HI, LO                         : result registers
// Multiply is shift-add, divide is restoring shift-subtract; both share the
// acc_hi/acc_lo pair ({HI,LO} product, or remainder/quotient) and opnd.
// Optional feature macro: MULDIV_SIGNED_EN (signed MULT/DIV). Without it every
// operation is unsigned and op[0] is ignored.
module ex_muldiv #(
    parameter int unsigned ITER = muldiv_pkg::ITER
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] Data_1,
    input  logic [31:0] Data_2,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    import muldiv_pkg::*;

    localparam int unsigned CW = $clog2(ITER + 1);

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   acc_hi;
    logic [31:0]   acc_lo;
    logic [31:0]   opnd;
    logic          is_div;
    logic          b_zero;

    logic          op_div;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    logic [31:0]   fin_hi;
    logic [31:0]   fin_lo;

    logic [32:0]   mul_sum;
    logic [32:0]   div_shift;
    logic [32:0]   div_diff;

    assign op_div = (op == OP_DIV) || (op == OP_DIVU);
    assign stall  = busy || (start && !flush);

`ifdef MULDIV_SIGNED_EN
    logic        sgn_op;
    logic        neg_q;
    logic        neg_r;
    logic [63:0] prod_adj;
    logic [31:0] quo_adj;
    logic [31:0] rem_adj;

    assign sgn_op = (op == OP_MULT) || (op == OP_DIV);

    muldiv_sign_adj u_sign_adj (
        .sgn      (sgn_op),
        .a        (Data_1),
        .b        (Data_2),
        .a_mag    (mag_a),
        .b_mag    (mag_b),
        .prod     ({acc_hi, acc_lo}),
        .prod_neg (neg_q),
        .prod_adj (prod_adj),
        .quo      (acc_lo),
        .quo_neg  (neg_q),
        .quo_adj  (quo_adj),
        .rem      (acc_hi),
        .rem_neg  (neg_r),
        .rem_adj  (rem_adj)
    );

    // A zero divisor keeps the raw all-ones quotient; the remainder negation
    // restores the original dividend in HI.
    assign fin_hi = is_div ? rem_adj : prod_adj[63:32];
    assign fin_lo = is_div ? (b_zero ? acc_lo : quo_adj) : prod_adj[31:0];
`else
    assign mag_a  = Data_1;
    assign mag_b  = Data_2;
    assign fin_hi = acc_hi;
    assign fin_lo = acc_lo;
`endif

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit (acc_lo[0]) is set, then shift the 65-bit result right.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);

    // Restoring step: bring the next dividend bit into the partial remainder;
    // bit 32 of the difference is the borrow (remainder < divisor).
    assign div_shift = {acc_hi, acc_lo[31]};
    assign div_diff  = div_shift - {1'b0, opnd};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            div0   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            b_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        count  <= '0;
                        is_div <= op_div;
                        b_zero <= (Data_2 == '0);
                        acc_hi <= '0;
                        if (op_div) begin
                            opnd   <= mag_b;
                            acc_lo <= mag_a;
                        end else begin
                            opnd   <= mag_a;
                            acc_lo <= mag_b;
                        end
`ifdef MULDIV_SIGNED_EN
                        neg_q <= sgn_op && (Data_1[31] ^ Data_2[31]);
                        neg_r <= sgn_op && op_div && Data_1[31];
`endif
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (is_div) begin
                            if (!div_diff[32]) begin
                                acc_hi <= div_diff[31:0];
                                acc_lo <= {acc_lo[30:0], 1'b1};
                            end else begin
                                acc_hi <= div_shift[31:0];
                                acc_lo <= {acc_lo[30:0], 1'b0};
                            end
                        end else begin
                            acc_hi <= mul_sum[32:1];
                            acc_lo <= {mul_sum[0], acc_lo[31:1]};
                        end
                        count <= count + 1'b1;
                        if (count == CW'(ITER - 1)) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        HI   <= fin_hi;
                        LO   <= fin_lo;
                        done <= 1'b1;
                        if (is_div) begin
                            div0 <= b_zero;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: table-driven directed check of ex_muldiv plus hand-written
// sequences for flush, start+flush, and mid-operation reset.
// Expected values cover both builds (with and without MULDIV_SIGNED_EN).
module tb_ex_muldiv;

    localparam logic [1:0] T_MULT  = 2'b00;
    localparam logic [1:0] T_MULTU = 2'b01;
    localparam logic [1:0] T_DIV   = 2'b10;
    localparam logic [1:0] T_DIVU  = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data_1 = '0;
    logic [31:0] data_2 = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    bit stall_dropped;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        bit          junk;
    } vec_t;

    vec_t vecs[$];

    ex_muldiv #(.ITER(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .Data_1 (data_1),
        .Data_2 (data_2),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .div0   (div0),
        .HI     (hi),
        .LO     (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input logic dz, input bit junk);
        vec_t v;
        v.name = name; v.op = o; v.a = a; v.b = b;
        v.hi = eh; v.lo = el; v.dz = dz; v.junk = junk;
        vecs.push_back(v);
    endtask

    // Issues one operation; returns the number of cycles from the start edge
    // until done is seen (-1 on timeout). With junk set, start stays high with
    // garbage operands while busy, which must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit junk, output int lat);
        int cyc;
        @(negedge clock);
        start = 1'b1; op = o; data_1 = a; data_2 = b;
        @(posedge clock);
        @(negedge clock);
        if (junk) begin
            op = T_DIVU; data_1 = 32'hDEADBEEF; data_2 = 32'h0;
        end else begin
            start = 1'b0;
        end
        cyc = 1;
        stall_dropped = 1'b0;
        while (!done && cyc < 100) begin
            if (!stall) stall_dropped = 1'b1;
            if (cyc == 32) start = 1'b0;
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        lat = done ? cyc : -1;
    endtask

    initial begin
        int lat;
        int cyc;
        int pulses;

        // Reset state, sampled while reset is held.
        repeat (2) @(negedge clock);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_div0", div0, 0);
        check("reset_stall", stall, 0);
        @(posedge clock);
        #2 reset = 1'b0;

        add("multu_max", T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        add("multu_shift", T_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 1'b1);
        add("divu_100_7", T_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
        add("divu_100_0", T_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 1'b0);
        add("multu_keeps_div0", T_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b1, 1'b0);
        add("divu_9_3", T_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1'b0);
        add("divu_big", T_DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, 1'b0);
        add("divu_small", T_DIVU, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 1'b0);
        add("multu_neg_bits", T_MULTU, 32'hFFFFFFFD, 32'd5, 32'd4, 32'hFFFFFFF1, 1'b0, 1'b0);
`ifdef MULDIV_SIGNED_EN
        add("mult_m3_5", T_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
        add("div_m7_2", T_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        add("div_min_m1", T_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b0);
        add("div_7_m2", T_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 1'b0);
        add("mult_m1_m1", T_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 1'b0);
`else
        add("mult_m3_5", T_MULT, 32'hFFFFFFFD, 32'd5, 32'd4, 32'hFFFFFFF1, 1'b0, 1'b0);
        add("div_m7_2", T_DIV, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 1'b0, 1'b0);
        add("div_min_m1", T_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 1'b0);
        add("div_7_m2", T_DIV, 32'd7, 32'hFFFFFFFE, 32'd7, 32'h0, 1'b0, 1'b0);
        add("mult_m1_m1", T_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0);
`endif
        add("div_m5_0", T_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1'b0);
        add("multu_hold_div0", T_MULTU, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 1'b1, 1'b0);

        // First vector starts on the first rising edge after reset release.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].junk, lat);
            check({vecs[i].name, "_latency"}, lat, 34);
            check({vecs[i].name, "_stall_held"}, stall_dropped, 0);
            check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
            check({vecs[i].name, "_div0"}, div0, vecs[i].dz);
            check({vecs[i].name, "_busy_at_done"}, busy, 0);
            @(negedge clock);
            check({vecs[i].name, "_done_pulse"}, done, 0);
        end

        // Flush in RUN at cycle 10, with start asserted alongside.
        @(negedge clock);
        start = 1'b1; op = T_MULTU; data_1 = 32'd5; data_2 = 32'd5;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (cyc = 1; cyc < 10; cyc++) @(negedge clock);
        check("flush_busy_before", busy, 1);
        flush = 1'b1; start = 1'b1;
        @(negedge clock);
        check("flush_busy_after", busy, 0);
        check("flush_stall", stall, 0);
        @(negedge clock);
        check("start_flush_ignored", busy, 0);
        start = 1'b0; flush = 1'b0;
        pulses = 0;
        repeat (40) begin @(negedge clock); if (done) pulses++; end
        check("flush_no_done", pulses, 0);
        check("flush_hi_kept", hi, 32'h1);
        check("flush_lo_kept", lo, 32'h0);

        // Flush in FIN (cycle 33, after the last step edge).
        @(negedge clock);
        start = 1'b1; op = T_MULTU; data_1 = 32'd3; data_2 = 32'd3;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (cyc = 1; cyc < 33; cyc++) @(negedge clock);
        check("fin_busy", busy, 1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("fin_flush_done", done, 0);
        check("fin_flush_busy", busy, 0);
        pulses = 0;
        repeat (5) begin @(negedge clock); if (done) pulses++; end
        check("fin_flush_no_done", pulses, 0);
        check("fin_flush_lo_kept", lo, 32'h0);
        check("fin_flush_div0_kept", div0, 1);

        // Reset pulsed at cycle 20 of a divide.
        @(negedge clock);
        start = 1'b1; op = T_DIV; data_1 = 32'h1234; data_2 = 32'h10;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (cyc = 1; cyc < 20; cyc++) @(negedge clock);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_reset_hi", hi, 0);
        check("mid_reset_lo", lo, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_div0", div0, 0);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin @(negedge clock); if (done || busy) pulses++; end
        check("post_reset_quiet", pulses, 0);
        run_op(T_MULTU, 32'd2, 32'd3, 1'b0, lat);
        check("post_reset_latency", lat, 34);
        check("post_reset_lo", lo, 32'd6);
        check("post_reset_hi", hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
